// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared states, op kinds and constants for the multdiv sequencer.
package multdiv_pkg;
  localparam int ITERS = 32;
  typedef enum logic [2:0] {IDLE, MULT_IT, DIV_ABSA, DIV_ABSB, DIV_IT, DIV_FIX, DONE_EXC} state_e;
  typedef enum logic {OP_MULT, OP_DIV} op_e;
  function automatic logic is_zero(input logic [31:0] v);
    return v == '0;
  endfunction
endpackage

// File: rtl/multdiv_seq_ctrl_if.sv
// multdiv_seq_ctrl_if: start pulses, operands and result handshake of the multdiv unit.
interface multdiv_seq_ctrl_if;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        data_exception, data_resultRDY, busy;
  modport master(output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
                 input data_result, data_exception, data_resultRDY, busy);
  modport slave(input ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
                output data_result, data_exception, data_resultRDY, busy);
endinterface

// File: rtl/adder32_md.sv
// adder32_md: 32-bit adder with carry in/out shared by every multdiv step.
module adder32_md (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {32'b0, cin};
endmodule

// File: rtl/multdiv_seq_ctrl.sv
// multdiv_seq_ctrl: sequential signed Booth multiply / restoring divide on one shared adder.
// MULTDIV_EARLY_ZERO_EN: finish zero-operand ops one cycle after start.
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] DIV0_RESULT = '0
) (
  input logic               clock,
  input logic               reset_n,
  multdiv_seq_ctrl_if.slave bus
);
  if (WIDTH != 32) begin : g_width_chk
    $error("multdiv_seq_ctrl: WIDTH must be 32");
  end
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
  logic        qm1_q, qm1_d, flag_q, flag_d, exc_q, exc_d, rdy_q, rdy_d;
  logic [31:0] add_x, add_y, sum;
  logic        add_cin, cout, neg_sel, start;
  logic [1:0]  booth;
  op_e         op;
  adder32_md u_add (.x(add_x), .y(add_y), .cin(add_cin), .sum(sum), .cout(cout));
  assign booth   = {lo_q[0], qm1_q};
  assign neg_sel = (state_q == DIV_ABSA) ? lo_q[31] : (state_q == DIV_ABSB) ? b_q[31] : flag_q;
  assign start   = bus.ctrl_MULT | bus.ctrl_DIV;
  assign op      = bus.ctrl_MULT ? OP_MULT : OP_DIV;
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state_q)
      MULT_IT: begin
        add_x   = hi_q;
        add_y   = (booth == 2'b01) ? b_q : (booth == 2'b10) ? ~b_q : '0;
        add_cin = booth == 2'b10;
      end
      DIV_ABSA, DIV_FIX: begin
        add_x   = neg_sel ? ~lo_q : lo_q;
        add_cin = neg_sel;
      end
      DIV_ABSB: begin
        add_x   = neg_sel ? ~b_q : b_q;
        add_cin = neg_sel;
      end
      DIV_IT: begin
        add_x   = {hi_q[30:0], lo_q[31]};
        add_y   = ~b_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end
  // flag_q is the quotient sign during a divide and the pending exception in DONE_EXC
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    qm1_d   = qm1_q;
    flag_d  = flag_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    case (state_q)
      MULT_IT: begin
        hi_d  = {add_x[31] ^ add_y[31] ^ cout, sum[31:1]};
        lo_d  = {sum[0], lo_q[31:1]};
        qm1_d = lo_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITERS - 1)) begin
          state_d = IDLE;
          res_d   = lo_d;
          exc_d   = hi_d != {32{lo_d[31]}};
          rdy_d   = 1'b1;
        end
      end
      DIV_ABSA: begin
        lo_d    = sum;
        state_d = DIV_ABSB;
      end
      DIV_ABSB: begin
        b_d     = sum;
        hi_d    = '0;
        cnt_d   = '0;
        state_d = DIV_IT;
      end
      DIV_IT: begin
        hi_d    = cout ? sum : add_x;
        lo_d    = {lo_q[30:0], cout};
        cnt_d   = cnt_q + 6'd1;
        state_d = (cnt_q == 6'(ITERS - 1)) ? DIV_FIX : DIV_IT;
      end
      DIV_FIX: begin
        res_d   = sum;
        exc_d   = ~flag_q & lo_q[31];
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      DONE_EXC: begin
        res_d   = lo_q;
        exc_d   = flag_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase
    if (start) begin
      hi_d   = '0;
      lo_d   = bus.data_operandA;
      b_d    = bus.data_operandB;
      qm1_d  = 1'b0;
      cnt_d  = '0;
      flag_d = bus.data_operandA[31] ^ bus.data_operandB[31];
      rdy_d  = 1'b0;
      if (op == OP_DIV && is_zero(bus.data_operandB)) begin
        state_d = DONE_EXC;
        lo_d    = DIV0_RESULT;
        flag_d  = 1'b1;
      end
`ifdef MULTDIV_EARLY_ZERO_EN
      else if (is_zero(bus.data_operandA) || is_zero(bus.data_operandB)) begin
        state_d = DONE_EXC;
        lo_d    = '0;
        flag_d  = 1'b0;
      end
`endif
      else state_d = (op == OP_MULT) ? MULT_IT : DIV_ABSA;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      qm1_q   <= 1'b0;
      flag_q  <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      qm1_q   <= qm1_d;
      flag_q  <= flag_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end
  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = state_q != IDLE;
endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// tb_multdiv_seq_ctrl: directed and random multiply/divide checks against an arithmetic model.
module tb_multdiv_seq_ctrl;
  localparam logic [31:0] DIV0 = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  multdiv_seq_ctrl_if bus ();
  multdiv_seq_ctrl #(.WIDTH(32), .DIV0_RESULT(DIV0)) dut (.clock(clk), .reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    longint p;
    if (!is_div) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      r   = p[31:0];
      e   = p != longint'($signed(r));
      lat = 32;
    end else if (b == 0) begin
      r = DIV0; e = 1'b1; lat = 1;
      return;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a; e = 1'b1; lat = 35;
    end else begin
      r = 32'($signed(a) / $signed(b)); e = 1'b0; lat = 35;
    end
`ifdef MULTDIV_EARLY_ZERO_EN
    if (a == 0 || b == 0) lat = 1;
`endif
  endfunction

  // called at a negedge; returns at the negedge right after the start edge
  task automatic start(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT = !is_div;
    bus.ctrl_DIV = is_div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (bus.data_resultRDY !== 1'b1 && lat < 100) begin
      busy_ok &= (bus.busy === 1'b1);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input bit is_div, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er, held;
    logic ee;
    int el, lat;
    bit busy_ok;
    model(is_div, a, b, er, ee, el);
    start(is_div, a, b);
    wait_rdy(lat, busy_ok);
    check({tag, " latency"}, 64'(lat), 64'(el));
    check({tag, " result"}, {32'b0, bus.data_result}, {32'b0, er});
    check({tag, " exc"}, {63'b0, bus.data_exception}, {63'b0, ee});
    check({tag, " busy"}, {63'b0, busy_ok}, 64'd1);
    held = bus.data_result;
    @(negedge clk);
    check({tag, " rdy pulse"}, {63'b0, bus.data_resultRDY}, 64'd0);
    check({tag, " held"}, {32'b0, bus.data_result}, {32'b0, held});
  endtask

  initial begin
    int lat, rdy_cnt;
    bit busy_ok;
    logic [31:0] a, b;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clk);
    check("reset result", {32'b0, bus.data_result}, 64'd0);
    check("reset flags", {61'b0, bus.data_exception, bus.data_resultRDY, bus.busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run("7*-3", 1'b0, 32'd7, -32'sd3);
    run("2^16*2^16", 1'b0, 32'h0001_0000, 32'h0001_0000);
    run("min*-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run("min*min", 1'b0, 32'h8000_0000, 32'h8000_0000);
    run("-100/7", 1'b1, -32'sd100, 32'd7);
    run("100/-7", 1'b1, 32'd100, -32'sd7);
    run("min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run("min/1", 1'b1, 32'h8000_0000, 32'd1);
    run("0*12345", 1'b0, 32'd0, 32'd12345);
    run("0/9", 1'b1, 32'd0, 32'd9);
    run("5/0", 1'b1, 32'd5, 32'd0);
    // abandon a divide with a reset pulse in mid-cycle
    start(1'b1, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst result", {32'b0, bus.data_result}, 64'd0);
    check("async rst flags", {61'b0, bus.data_exception, bus.data_resultRDY, bus.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      rdy_cnt += int'(bus.data_resultRDY);
    end
    check("no rdy after rst", 64'(rdy_cnt), 64'd0);
    // restart a running multiply with a divide
    start(1'b0, 32'd123, 32'd456);
    rdy_cnt = 0;
    repeat (9) begin
      @(negedge clk);
      rdy_cnt += int'(bus.data_resultRDY);
    end
    start(1'b1, 32'd9, 32'd3);
    wait_rdy(lat, busy_ok);
    check("restart early rdy", 64'(rdy_cnt), 64'd0);
    check("restart latency", 64'(lat), 64'd35);
    check("restart result", {32'b0, bus.data_result}, 64'd3);
    check("restart busy", {63'b0, busy_ok}, 64'd1);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      if (i % 8 == 7) a = 32'h8000_0000;
      run($sformatf("rnd%0d", i), i[0], a, b);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
